// File: rtl/imm_gen_pkg.sv
// Shared definitions for the immediate-generation stage.
//   imm_fmt_e : format code presented on out_fmt
//   OPC_*     : RV32/RV64 major opcodes (instr[6:0])
//   is_shift_f3 : OP-IMM / OP-IMM-32 funct3 values that carry a shamt
package imm_gen_pkg;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_SH  = 3'd6,
        FMT_ILL = 3'd7
    } imm_fmt_e;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    function automatic logic is_shift_f3(input logic [2:0] f3);
        return (f3 == 3'b001) || (f3 == 3'b101);
    endfunction

endpackage

// File: rtl/imm_gen_stage_decode.sv
// Combinational immediate decoder.
//   instr_i   : 32-bit instruction word
//   imm_o     : XLEN-wide sign/zero-extended immediate
//   fmt_o     : decoded format
//   illegal_o : opcode (or shamt/width combination) not decodable
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic [31:0]     instr_i,
    output logic [XLEN-1:0] imm_o,
    output imm_fmt_e        fmt_o,
    output logic            illegal_o
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        s;
    logic [63:0] imm64;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign s      = instr_i[31];

    // Built at 64 bits and truncated; sign extension from bit 31 makes
    // the low XLEN bits identical to a native XLEN-wide extension.
    always_comb begin
        imm64     = '0;
        fmt_o     = FMT_R;
        illegal_o = 1'b0;
        case (opcode)
            OPC_LOAD, OPC_JALR: begin
                fmt_o = FMT_I;
                imm64 = {{52{s}}, instr_i[31:20]};
            end
            OPC_OP_IMM: begin
                if (is_shift_f3(funct3)) begin
                    if (XLEN == 64) begin
                        fmt_o = FMT_SH;
                        imm64 = {58'd0, instr_i[25:20]};
                    end else if (instr_i[25]) begin
                        fmt_o     = FMT_ILL;
                        illegal_o = 1'b1;
                    end else begin
                        fmt_o = FMT_SH;
                        imm64 = {59'd0, instr_i[24:20]};
                    end
                end else begin
                    fmt_o = FMT_I;
                    imm64 = {{52{s}}, instr_i[31:20]};
                end
            end
            OPC_OP_IMM_32: begin
                if (XLEN != 64) begin
                    fmt_o     = FMT_ILL;
                    illegal_o = 1'b1;
                end else if (is_shift_f3(funct3)) begin
                    fmt_o = FMT_SH;
                    imm64 = {59'd0, instr_i[24:20]};
                end else begin
                    fmt_o = FMT_I;
                    imm64 = {{52{s}}, instr_i[31:20]};
                end
            end
            OPC_STORE: begin
                fmt_o = FMT_S;
                imm64 = {{52{s}}, instr_i[31:25], instr_i[11:7]};
            end
            OPC_BRANCH: begin
                fmt_o = FMT_B;
                imm64 = {{52{s}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
            end
            OPC_LUI, OPC_AUIPC: begin
                fmt_o = FMT_U;
                imm64 = {{32{s}}, instr_i[31:12], 12'd0};
            end
            OPC_JAL: begin
                fmt_o = FMT_J;
                imm64 = {{44{s}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
            end
            OPC_OP: fmt_o = FMT_R;
            OPC_OP_32: begin
                if (XLEN != 64) begin
                    fmt_o     = FMT_ILL;
                    illegal_o = 1'b1;
                end
            end
            OPC_SYSTEM: begin
                // CSR address, zero-extended
                fmt_o = FMT_I;
                imm64 = {52'd0, instr_i[31:20]};
            end
            default: begin
                fmt_o     = FMT_ILL;
                illegal_o = 1'b1;
            end
        endcase
    end

    assign imm_o = imm64[XLEN-1:0];

endmodule

// File: rtl/imm_gen_stage.sv
// Registered, handshaked immediate-generation stage with a 2-entry
// output/skid buffer and a saturating illegal-instruction counter.
//   clk, rst_n            : clock, async active-low reset
//   flush                 : drop all buffered entries (sync)
//   in_valid/in_ready     : input handshake; in_instr, in_tag payload
//   out_valid/out_ready   : output handshake; out_imm/fmt/illegal/tag payload
//   illegal_cnt           : accepted illegal instructions, saturating
module imm_gen_stage
    import imm_gen_pkg::*;
#(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned TAG_W = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output imm_fmt_e         out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag,
    output logic [CNT_W-1:0] illegal_cnt
);

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        imm_fmt_e         fmt;
        logic             illegal;
        logic [TAG_W-1:0] tag;
    } entry_t;

    logic [XLEN-1:0] dec_imm;
    imm_fmt_e        dec_fmt;
    logic            dec_illegal;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .instr_i   (in_instr),
        .imm_o     (dec_imm),
        .fmt_o     (dec_fmt),
        .illegal_o (dec_illegal)
    );

    entry_t          o_q, o_d, k_q, k_d, new_entry;
    logic            o_valid_q, o_valid_d, k_valid_q, k_valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            accept;

    assign new_entry = '{imm: dec_imm, fmt: dec_fmt, illegal: dec_illegal, tag: in_tag};
    // in_ready depends only on registered skid state
    assign accept    = in_valid && !k_valid_q && !flush;

    always_comb begin
        o_d       = o_q;
        o_valid_d = o_valid_q;
        k_d       = k_q;
        k_valid_d = k_valid_q;
        cnt_d     = cnt_q;
        if (flush) begin
            o_valid_d = 1'b0;
            k_valid_d = 1'b0;
        end else begin
            if (o_valid_q && out_ready && k_valid_q) begin
                // skid drains into O; accept is impossible while K is full
                o_d       = k_q;
                k_valid_d = 1'b0;
            end else if (!o_valid_q || out_ready) begin
                o_valid_d = accept;
                if (accept) o_d = new_entry;
            end else if (accept) begin
                k_d       = new_entry;
                k_valid_d = 1'b1;
            end
            if (accept && dec_illegal && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_q       <= '{imm: '0, fmt: FMT_R, illegal: 1'b0, tag: '0};
            k_q       <= '{imm: '0, fmt: FMT_R, illegal: 1'b0, tag: '0};
            o_valid_q <= 1'b0;
            k_valid_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            o_q       <= o_d;
            k_q       <= k_d;
            o_valid_q <= o_valid_d;
            k_valid_q <= k_valid_d;
            cnt_q     <= cnt_d;
        end
    end

    assign in_ready    = !k_valid_q;
    assign out_valid   = o_valid_q;
    assign out_imm     = o_q.imm;
    assign out_fmt     = o_q.fmt;
    assign out_illegal = o_q.illegal;
    assign out_tag     = o_q.tag;
    assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_imm_gen_stage.sv
module tb_imm_gen_stage;
    import imm_gen_pkg::*;

    logic clk;
    logic rst_n;

    // XLEN=64 instance
    logic        flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
    logic [31:0] in_instr;
    logic [7:0]  in_tag, out_tag;
    logic [63:0] out_imm;
    imm_fmt_e    out_fmt;
    logic [15:0] illegal_cnt;

    // XLEN=32, CNT_W=4 instance
    logic        s_flush, s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_illegal;
    logic [31:0] s_in_instr;
    logic [7:0]  s_in_tag, s_out_tag;
    logic [31:0] s_out_imm;
    imm_fmt_e    s_out_fmt;
    logic [3:0]  s_illegal_cnt;

    imm_gen_stage #(.XLEN(64), .TAG_W(8), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
        .out_fmt(out_fmt), .out_illegal(out_illegal), .out_tag(out_tag),
        .illegal_cnt(illegal_cnt)
    );

    imm_gen_stage #(.XLEN(32), .TAG_W(8), .CNT_W(4)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .flush(s_flush),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_instr(s_in_instr), .in_tag(s_in_tag),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_imm(s_out_imm),
        .out_fmt(s_out_fmt), .out_illegal(s_out_illegal), .out_tag(s_out_tag),
        .illegal_cnt(s_illegal_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference decode from the ISA field definitions, using integer arithmetic.
    function automatic void ref_dec(input int xlen, input logic [31:0] w,
                                    output logic [63:0] imm, output logic [2:0] fmt,
                                    output logic ill);
        int unsigned op = 32'(w & 32'h7F);
        int unsigned f3 = 32'((w >> 12) & 32'h7);
        longint v = 0;
        fmt = 3'd0; ill = 1'b0;
        case (op)
            'h03, 'h67: begin fmt = 3'd1; v = w >> 20; if (v >= 2048) v -= 4096; end
            'h13: begin
                if (f3 == 1 || f3 == 5) begin
                    if (xlen == 64) begin fmt = 3'd6; v = (w >> 20) & 63; end
                    else if (((w >> 25) & 1) == 1) begin fmt = 3'd7; ill = 1'b1; end
                    else begin fmt = 3'd6; v = (w >> 20) & 31; end
                end else begin fmt = 3'd1; v = w >> 20; if (v >= 2048) v -= 4096; end
            end
            'h1B: begin
                if (xlen == 32) begin fmt = 3'd7; ill = 1'b1; end
                else if (f3 == 1 || f3 == 5) begin fmt = 3'd6; v = (w >> 20) & 31; end
                else begin fmt = 3'd1; v = w >> 20; if (v >= 2048) v -= 4096; end
            end
            'h23: begin
                fmt = 3'd2; v = ((w >> 25) << 5) | ((w >> 7) & 31);
                if (v >= 2048) v -= 4096;
            end
            'h63: begin
                fmt = 3'd3;
                v = (((w >> 31) & 1) << 12) | (((w >> 7) & 1) << 11) |
                    (((w >> 25) & 63) << 5) | (((w >> 8) & 15) << 1);
                if (v >= 4096) v -= 8192;
            end
            'h37, 'h17: begin
                fmt = 3'd4; v = w & 32'hFFFFF000;
                if (v >= 64'h8000_0000) v -= 64'h1_0000_0000;
            end
            'h6F: begin
                fmt = 3'd5;
                v = (((w >> 31) & 1) << 20) | (w & 32'h000FF000) |
                    (((w >> 20) & 1) << 11) | (((w >> 21) & 32'h3FF) << 1);
                if (v >= 64'h10_0000) v -= 64'h20_0000;
            end
            'h33: fmt = 3'd0;
            'h3B: if (xlen == 32) begin fmt = 3'd7; ill = 1'b1; end
            'h73: begin fmt = 3'd1; v = w >> 20; end
            default: begin fmt = 3'd7; ill = 1'b1; end
        endcase
        imm = 64'(v);
        if (xlen == 32) imm = imm & 64'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w = $urandom();
        case ($urandom_range(0, 13))
            0: w[6:0] = 7'h03;   1: w[6:0] = 7'h13;   2: w[6:0] = 7'h17;
            3: w[6:0] = 7'h1B;   4: w[6:0] = 7'h23;   5: w[6:0] = 7'h33;
            6: w[6:0] = 7'h37;   7: w[6:0] = 7'h3B;   8: w[6:0] = 7'h63;
            9: w[6:0] = 7'h67;  10: w[6:0] = 7'h6F;  11: w[6:0] = 7'h73;
            default: ;
        endcase
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard for the XLEN=64 instance
    typedef logic [75:0] word_t;
    word_t       sb[$];
    word_t       prev_word;
    logic        prev_hold = 1'b0;
    int          n_out = 0;
    logic [15:0] exp_cnt = '0;
    logic [63:0] m_imm;
    logic [2:0]  m_fmt;
    logic        m_ill;

    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            exp_cnt   = '0;
            prev_hold = 1'b0;
        end else begin
            if (prev_hold)
                check("hold_stable", {out_imm, 3'(out_fmt), out_illegal, out_tag}, prev_word);
            prev_hold = out_valid && !out_ready && !flush;
            prev_word = {out_imm, 3'(out_fmt), out_illegal, out_tag};
            if (flush) begin
                sb.delete();
            end else begin
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) check("spurious_out_valid", out_valid, 1'b0);
                    else begin
                        check("pop_entry", {out_imm, 3'(out_fmt), out_illegal, out_tag}, sb.pop_front());
                        n_out++;
                    end
                end
                if (in_valid && in_ready) begin
                    ref_dec(64, in_instr, m_imm, m_fmt, m_ill);
                    sb.push_back({m_imm, m_fmt, m_ill, in_tag});
                    if (m_ill && exp_cnt != 16'hFFFF) exp_cnt++;
                end
            end
        end
    end

    logic [3:0] c32 = '0;

    task automatic send32(input logic [31:0] w);
        logic [63:0] e_imm; logic [2:0] e_fmt; logic e_ill; logic [7:0] t;
        t = 8'($urandom());
        s_in_valid = 1'b1; s_in_instr = w; s_in_tag = t;
        tick();
        s_in_valid = 1'b0;
        ref_dec(32, w, e_imm, e_fmt, e_ill);
        if (e_ill && c32 != 4'hF) c32++;
        check("x32_valid", s_out_valid, 1'b1);
        check("x32_entry", {s_out_imm, 3'(s_out_fmt), s_out_illegal, s_out_tag},
              {e_imm[31:0], e_fmt, e_ill, t});
        check("x32_cnt", s_illegal_cnt, c32);
    endtask

    task automatic send64(input logic [31:0] w, input logic [63:0] e_imm, input logic [2:0] e_fmt);
        in_valid = 1'b1; in_instr = w; in_tag = 8'h5A;
        tick();
        in_valid = 1'b0;
        check("dir_valid", out_valid, 1'b1);
        check("dir_imm", out_imm, e_imm);
        check("dir_fmt", out_fmt, e_fmt);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] bp[4];
        int base, i, c, accepted;
        logic acc;
        logic [15:0] saved_cnt;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_tag = '0; out_ready = 1'b1;
        s_flush = 1'b0; s_in_valid = 1'b0; s_in_instr = '0; s_in_tag = '0; s_out_ready = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_imm", out_imm, 64'd0);
        check("rst_out_fmt", out_fmt, 3'd0);
        check("rst_out_illegal", out_illegal, 1'b0);
        check("rst_out_tag", out_tag, 8'd0);
        check("rst_cnt", illegal_cnt, 16'd0);
        check("rst_cnt32", s_illegal_cnt, 4'd0);

        // XLEN=32: shift width, OP-IMM-32 illegal, random decode, saturation
        send32(32'h03F09093);
        check("x32_slli63_ill", s_out_illegal, 1'b1);
        check("x32_cnt_one", s_illegal_cnt, 4'd1);
        send32(32'h0000001B);
        check("x32_opimm32_ill", s_out_illegal, 1'b1);
        send32(32'h00509093);
        check("x32_slli5_imm", s_out_imm, 32'd5);
        for (int k = 0; k < 30; k++) send32(rand_instr());
        for (int k = 0; k < 20; k++) send32(32'h0000007F);
        check("x32_cnt_sat", s_illegal_cnt, 4'd15);

        // XLEN=64 directed formats
        send64(32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1);
        send64(32'hFE000EE3, 64'hFFFF_FFFF_FFFF_FFFC, 3'd3);
        send64(32'h123452B7, 64'h0000_0000_1234_5000, 3'd4);
        send64(32'h03F09093, 64'd63, 3'd6);
        tick();

        // Backpressure: out_ready low for 3 cycles after the first
        for (int k = 0; k < 4; k++) bp[k] = rand_instr();
        base = n_out; i = 0; c = 0;
        while ((n_out - base) < 4 && c < 30) begin
            out_ready = !(c >= 1 && c <= 3);
            in_valid  = (i < 4);
            if (i < 4) begin in_instr = bp[i]; in_tag = 8'(8'hA0 + i); end
            acc = in_valid && in_ready;
            tick();
            if (acc) i++;
            if (c == 1) check("bp_in_ready_low", in_ready, 1'b0);
            if (c == 1) check("bp_first_tag", out_tag, 8'hA0);
            c++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        check("bp_count", n_out - base, 4);
        tick();

        // Full throughput: 100 instructions
        base = n_out; accepted = 0;
        for (int k = 0; k < 100; k++) begin
            in_valid = 1'b1; in_instr = rand_instr(); in_tag = 8'(k);
            if (in_ready) accepted++;
            tick();
        end
        in_valid = 1'b0;
        tick();
        check("tp_accepted", accepted, 100);
        check("tp_outputs", n_out - base, 100);
        check("tp_cnt", illegal_cnt, exp_cnt);

        // Flush with O and K full
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h0000007F; in_tag = 8'h11; tick();
        in_instr = 32'h00000013; in_tag = 8'h12; tick();
        in_valid = 1'b0;
        check("fl_out_valid_pre", out_valid, 1'b1);
        check("fl_in_ready_pre", in_ready, 1'b0);
        check("fl_cnt_pre", illegal_cnt, exp_cnt);
        saved_cnt = illegal_cnt;
        flush = 1'b1; in_valid = 1'b1; in_instr = 32'h0000007F;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_out_valid", out_valid, 1'b0);
        check("fl_in_ready", in_ready, 1'b1);
        check("fl_cnt_kept", illegal_cnt, saved_cnt);
        out_ready = 1'b1;
        tick();

        // Mid-stream asynchronous reset
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'hFFF00093; in_tag = 8'h77;
        tick();
        in_instr = 32'h0000007F; tick();
        #2 rst_n = 1'b0;
        #1;
        check("ar_out_valid", out_valid, 1'b0);
        check("ar_in_ready", in_ready, 1'b1);
        check("ar_out_imm", out_imm, 64'd0);
        check("ar_out_fmt", out_fmt, 3'd0);
        check("ar_out_tag", out_tag, 8'd0);
        check("ar_cnt", illegal_cnt, 16'd0);
        in_valid = 1'b0; out_ready = 1'b1;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        check("ar_post_valid", out_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
